// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR checker and its companion scrambler.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } lfsr_state_e;

  localparam logic [15:0] LFSR_DEFAULT_POLY = 16'b1000_0000_0001_1100;

  // Words wider than this are truncated before counting.
  localparam int POPCOUNT_MAX_BITS = 64;

  function automatic logic [6:0] popcount(input logic [POPCOUNT_MAX_BITS-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < POPCOUNT_MAX_BITS; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR advance: produces one word MSB-first and the
// state that follows it.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int          p_BITS_PER_CLOCK = 8,
  parameter logic [15:0] p_POLYNOMIAL     = LFSR_DEFAULT_POLY
) (
  input  logic [15:0]                 i_STATE,
  output logic [p_BITS_PER_CLOCK-1:0] o_WORD,
  output logic [15:0]                 o_NEXT_STATE
);

  logic [15:0] w_state;
  logic        w_bit;

  // NOTE: blocking assignments here so each loop iteration sees the state the
  // previous bit produced; every output gets a default first so no latch forms.
  always_comb begin
    w_state = i_STATE;
    w_bit   = 1'b0;
    o_WORD  = '0;
    for (int i = p_BITS_PER_CLOCK - 1; i >= 0; i--) begin
      w_bit     = ^(w_state & p_POLYNOMIAL);
      o_WORD[i] = w_bit;
      w_state   = {w_state[14:0], w_bit};
    end
    o_NEXT_STATE = w_state;
  end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker: seeds from the received stream, verifies it, then tracks lock
// and counts bit errors against a locally generated Fibonacci LFSR sequence.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int          p_BITS_PER_CLOCK = 8,
  parameter logic [15:0] p_POLYNOMIAL     = LFSR_DEFAULT_POLY,
  parameter int          p_LOCK_COUNT     = 4,
  parameter int          p_LOSS_COUNT     = 3
) (
  input  logic                        i_CLK,
  input  logic                        i_RESET_N,
  input  logic                        i_VALID,
  input  logic [p_BITS_PER_CLOCK-1:0] i_DATA,
  input  logic                        i_CLR_CNT,
  output logic                        o_LOCK,
  output logic                        o_ERR,
  output logic [15:0]                 o_ERR_CNT,
  output logic [1:0]                  o_STATE
);

  localparam int c_SEED_WORDS = (16 + p_BITS_PER_CLOCK - 1) / p_BITS_PER_CLOCK;
  localparam int c_SEED_W     = $clog2(c_SEED_WORDS + 1);
  localparam int c_GOOD_W     = $clog2(p_LOCK_COUNT + 1);
  localparam int c_BAD_W      = $clog2(p_LOSS_COUNT + 1);

  localparam logic [c_SEED_W-1:0] c_SEED_LAST = c_SEED_W'(c_SEED_WORDS - 1);
  localparam logic [c_GOOD_W-1:0] c_GOOD_LAST = c_GOOD_W'(p_LOCK_COUNT - 1);
  localparam logic [c_BAD_W-1:0]  c_BAD_LAST  = c_BAD_W'(p_LOSS_COUNT - 1);

  lfsr_state_e           r_state;
  logic [15:0]           r_s;
  logic [c_SEED_W-1:0]   r_seed_cnt;
  logic [c_GOOD_W-1:0]   r_good_cnt;
  logic [c_BAD_W-1:0]    r_bad_cnt;
  logic                  r_err;
  logic [15:0]           r_err_cnt;

  logic [p_BITS_PER_CLOCK-1:0]  w_exp_word;
  logic [15:0]                  w_gen_state;
  logic [p_BITS_PER_CLOCK-1:0]  w_mismatch;
  logic                         w_any_err;
  logic [6:0]                   w_pop;
  logic [15+p_BITS_PER_CLOCK:0] w_seed_cat;
  logic [16:0]                  w_cnt_sum;

  lfsr_step #(
    .p_BITS_PER_CLOCK (p_BITS_PER_CLOCK),
    .p_POLYNOMIAL     (p_POLYNOMIAL)
  ) u_step (
    .i_STATE      (r_s),
    .o_WORD       (w_exp_word),
    .o_NEXT_STATE (w_gen_state)
  );

  assign w_mismatch = w_exp_word ^ i_DATA;
  assign w_any_err  = |w_mismatch;
  assign w_pop      = popcount(POPCOUNT_MAX_BITS'(w_mismatch));
  // Seeding keeps only the most recent 16 received bits, MSB-first.
  assign w_seed_cat = {r_s, i_DATA};
  assign w_cnt_sum  = {1'b0, r_err_cnt} + 17'(w_pop);

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      r_state    <= ST_SEED;
      r_s        <= 16'hFFFF;
      r_seed_cnt <= '0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_SEED: if (i_VALID) begin
          r_s <= w_seed_cat[15:0];
          if (r_seed_cnt == c_SEED_LAST) begin
            r_seed_cnt <= '0;
            r_state    <= ST_VERIFY;
          end else begin
            r_seed_cnt <= r_seed_cnt + 1'b1;
          end
        end
        ST_VERIFY: if (i_VALID) begin
          r_s <= w_gen_state;
          if (w_any_err) begin
            r_good_cnt <= '0;
            r_state    <= ST_SEED;
          end else if (r_good_cnt == c_GOOD_LAST) begin
            r_good_cnt <= '0;
            r_state    <= ST_LOCKED;
          end else begin
            r_good_cnt <= r_good_cnt + 1'b1;
          end
        end
        ST_LOCKED: if (i_VALID) begin
          r_s <= w_gen_state;
          if (w_any_err) begin
            r_err <= 1'b1;
            if (r_bad_cnt == c_BAD_LAST) begin
              r_bad_cnt <= '0;
              r_state   <= ST_SEED;
            end else begin
              r_bad_cnt <= r_bad_cnt + 1'b1;
            end
          end else begin
            r_bad_cnt <= '0;
          end
        end
        default: begin
          r_state    <= ST_SEED;
          r_seed_cnt <= '0;
          r_good_cnt <= '0;
          r_bad_cnt  <= '0;
        end
      endcase

      // Clear takes priority over accumulating the word consumed this cycle.
      if (i_CLR_CNT) begin
        r_err_cnt <= '0;
      end else if (i_VALID && r_state == ST_LOCKED) begin
        r_err_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
      end
    end
  end

  assign o_LOCK    = (r_state == ST_LOCKED);
  assign o_ERR     = r_err;
  assign o_ERR_CNT = r_err_cnt;
  assign o_STATE   = r_state;

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL have parameter p_BITS_PER_CLOCK, default 8, giving the received bits per valid word.
REQ-002 The block SHALL have parameter p_POLYNOMIAL, default 16'b1000_0000_0001_1100, giving the 16-bit tap mask (bit n = state bit n tapped).
REQ-003 The block SHALL have parameter p_LOCK_COUNT, default 4, giving the consecutive error-free words needed to declare lock.
REQ-004 The block SHALL have parameter p_LOSS_COUNT, default 3, giving the consecutive errored words needed to drop lock.
REQ-005 The block SHALL have the following ports, clock and reset first:
  i_CLK  input  1  single clock; all state on rising edge.
  i_RESET_N  input  1  asynchronous, active-low reset.
  i_VALID  input  1  i_DATA carries a word this cycle.
  i_DATA  input  p_BITS_PER_CLOCK  received LFSR word; MSB is the earliest bit.
  i_CLR_CNT  input  1  synchronous clear of o_ERR_CNT.
  o_LOCK  output  1  checker is locked to the sequence.
  o_ERR  output  1  one-cycle pulse: last locked word had at least one bit error.
  o_ERR_CNT  output  16  saturating count of bit errors seen while locked.
  o_STATE  output  2  current FSM state encoding (debug).

Function
REQ-006 The block SHALL model the sequence as a Fibonacci LFSR: generated bit b = parity(S & p_POLYNOMIAL); next S = {S[14:0], b}; a word's bits are generated MSB-first.
REQ-007 The block SHALL act only on cycles with i_VALID=1; with i_VALID=0 the LFSR state, counters and FSM SHALL hold and o_ERR SHALL be 0.
REQ-008 The FSM SHALL have states SEED=0, VERIFY=1, LOCKED=2; encoding 3 is unreachable and SHALL return to SEED.
REQ-009 In SEED, each valid word SHALL shift into S MSB-first (S = {S[14:0], rx_bit} per bit); after ceil(16/p_BITS_PER_CLOCK) valid words the FSM SHALL enter VERIFY.
REQ-010 In VERIFY and LOCKED, the expected word SHALL be generated from S, compared bitwise with i_DATA, and S SHALL advance on the generated bits, never the received bits.
REQ-011 In VERIFY, a word with zero mismatches SHALL increment a good-run counter; on reaching p_LOCK_COUNT the FSM SHALL enter LOCKED. Any mismatch SHALL return it to SEED and clear the good-run counter.
REQ-012 In LOCKED, a word with any mismatch SHALL increment a bad-run counter, and an error-free word SHALL clear it; on reaching p_LOSS_COUNT the FSM SHALL enter SEED.
REQ-013 o_ERR SHALL be asserted for exactly the cycle after a mismatching valid word is consumed in LOCKED, including the word that causes loss of lock.
REQ-014 o_ERR_CNT SHALL add the word's mismatch popcount (0..p_BITS_PER_CLOCK) one cycle after a valid LOCKED word, and SHALL saturate at 16'hFFFF without wrapping.
REQ-015 i_CLR_CNT=1 SHALL set o_ERR_CNT to 0 on the next edge; if a counted word is consumed in the same cycle, the clear SHALL win and that word's errors SHALL be discarded.
REQ-016 o_LOCK SHALL be 1 exactly while the registered state is LOCKED, and SHALL deassert on the edge that enters SEED.
REQ-017 Errors during SEED and VERIFY SHALL NOT affect o_ERR or o_ERR_CNT.

Reset
REQ-018 Asserting i_RESET_N low SHALL immediately force: state SEED, S 16'hFFFF, good-run, bad-run and seed-word counters 0, o_LOCK 0, o_ERR 0, o_ERR_CNT 0, o_STATE 0.
REQ-019 Reset deasserted mid-word or mid-lock SHALL restart from SEED; the first valid word after release SHALL be treated as seed word 0.

Structure
REQ-020 A shared package lfsr_pkg SHALL hold the FSM state enum, the default polynomial constant, and a popcount function.
REQ-021 Next-word generation (S, polynomial -> word, next S) SHALL be a combinational sub-module lfsr_step, reusable by the scrambler.

Verification
REQ-022 Clean lock: W=8, golden LFSR seeded 16'hACE1 driving valid every cycle -> o_LOCK rises after 2 seed words + 4 verify words (edge after the 6th word); o_ERR_CNT stays 0.
REQ-023 Single-bit error: when locked, flip bit 0 of one word -> o_ERR pulses for 1 cycle, o_ERR_CNT=1, o_LOCK stays 1, and the next word is error-free (no propagation).
REQ-024 Loss of lock: when locked, inject 3 consecutive words of all 8 bits inverted -> o_ERR_CNT=24, o_LOCK falls on the edge after the 3rd word, o_STATE=0; clean stream relocks after 6 more words.
REQ-025 Saturation and clear: force 8192+1 fully inverted locked words with p_LOSS_COUNT raised above that -> o_ERR_CNT holds 16'hFFFF; i_CLR_CNT together with an errored word -> o_ERR_CNT=0.
REQ-026 Gaps and reset: insert random i_VALID=0 cycles during seed and lock -> same lock point in word count; assert i_RESET_N low while locked -> o_LOCK=0 and o_ERR_CNT=0 with no clock edge.
REQ-027 Verify failure: corrupt the 2nd VERIFY word -> FSM returns to SEED with no o_ERR pulse and o_ERR_CNT unchanged.
